// File: rtl/fir_xifu_ex.sv
// rtl/fir_xifu_ex.sv - FIR XIFU execute stage: buffer write strobes and serial dot-product MAC
//
// Accepts decoded FIR instructions from the decode stage. PUSH, TAP and CLR turn into
// one-cycle strobes towards the tap/sample buffer controller. DOT runs NB_TAPS serial
// multiply-accumulate cycles over taps_i/samples_i. Every accepted instruction yields
// exactly one writeback response, held stable until wb_ready_i.
//
// Build option: define FIR_XIFU_EX_SAT_EN to saturate the shifted dot-product result to
// signed 32-bit. Without it the low 32 bits are returned (wrap).
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  kills the in-flight instruction, gates strobes and wb_valid_o
//   id_valid_i / id_ready_o  instruction handshake from decode
//   id_op_i                  00 PUSH, 01 TAP, 10 DOT, 11 CLR
//   id_rs1_i, id_rs2_i       operands (sample / packed tap word, tap word index)
//   id_rd_i, id_tag_i        destination register and tag, echoed in the response
//   taps_i, samples_i        buffer contents, entry k at [k*DATA_WIDTH +: DATA_WIDTH]
//   tap_we_o, tap_idx_o      tap word write strobe and word index
//   sample_push_o            sample shift-in strobe
//   sample_clr_o             sample buffer clear strobe
//   ctrl_wdata_o             data for tap write / sample push
//   wb_valid_o / wb_ready_i  response handshake towards writeback
//   wb_we_o, wb_rd_o, wb_data_o, wb_tag_o  response fields

module fir_xifu_ex #(
    parameter int NB_TAPS    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 0,
    parameter int TAG_WIDTH  = 4,
    localparam int TAPS_PER_WORD = 32 / DATA_WIDTH,
    localparam int NB_WORDS      = NB_TAPS / TAPS_PER_WORD,
    localparam int IDX_WIDTH     = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          id_valid_i,
    output logic                          id_ready_o,
    input  logic [1:0]                    id_op_i,
    input  logic [31:0]                   id_rs1_i,
    input  logic [31:0]                   id_rs2_i,
    input  logic [4:0]                    id_rd_i,
    input  logic [TAG_WIDTH-1:0]          id_tag_i,
    input  logic [NB_TAPS*DATA_WIDTH-1:0] taps_i,
    input  logic [NB_TAPS*DATA_WIDTH-1:0] samples_i,
    output logic                          tap_we_o,
    output logic [IDX_WIDTH-1:0]          tap_idx_o,
    output logic [31:0]                   ctrl_wdata_o,
    output logic                          sample_push_o,
    output logic                          sample_clr_o,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic                          wb_we_o,
    output logic [4:0]                    wb_rd_o,
    output logic [31:0]                   wb_data_o,
    output logic [TAG_WIDTH-1:0]          wb_tag_o
);

    localparam int CNT_WIDTH  = (NB_TAPS > 1) ? $clog2(NB_TAPS) : 1;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    // Wide enough to sum NB_TAPS full-scale products without overflow.
    localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(NB_TAPS) + 1;
    // At least 33 bits so the bits above bit 31 always exist for the range check.
    localparam int EXT_WIDTH  = (ACC_WIDTH > 33) ? ACC_WIDTH : 33;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_TAP  = 2'b01;
    localparam logic [1:0] OP_DOT  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [CNT_WIDTH-1:0] LAST_K = CNT_WIDTH'(NB_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                       state_q;
    logic [31:0]                  rs1_q;
    logic [IDX_WIDTH-1:0]         idx_q;
    logic [4:0]                   rd_q;
    logic [TAG_WIDTH-1:0]         tag_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic                         tap_we_q;
    logic                         push_q;
    logic                         clr_q;
    logic                         wb_we_q;
    logic [31:0]                  wb_data_q;

    // MAC datapath: one tap/sample pair per cycle, selected by the counter.
    logic signed [DATA_WIDTH-1:0] tap_k;
    logic signed [DATA_WIDTH-1:0] sample_k;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [EXT_WIDTH-1:0]  acc_ext;
    logic signed [EXT_WIDTH-1:0]  shifted;
    logic [31:0]                  result;
    logic                         unused_bits;

    assign tap_k    = taps_i[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
    assign sample_k = samples_i[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
    assign product  = tap_k * sample_k;
    assign acc_sum  = acc_q + ACC_WIDTH'(product);
    assign acc_ext  = EXT_WIDTH'(acc_sum);
    assign shifted  = acc_ext >>> SHIFT;

`ifdef FIR_XIFU_EX_SAT_EN
    // In range exactly when bits 31 and above are all copies of the sign.
    logic fits;
    assign fits   = (&shifted[EXT_WIDTH-1:31]) | ~(|shifted[EXT_WIDTH-1:31]);
    assign result = fits ? shifted[31:0]
                         : (shifted[EXT_WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    assign unused_bits = ^id_rs2_i[31:IDX_WIDTH];
`else
    assign result      = shifted[31:0];
    assign unused_bits = ^{id_rs2_i[31:IDX_WIDTH], shifted[EXT_WIDTH-1:32]};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rs1_q     <= '0;
            idx_q     <= '0;
            rd_q      <= '0;
            tag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tap_we_q  <= 1'b0;
            push_q    <= 1'b0;
            clr_q     <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_data_q <= '0;
        end else begin
            // Strobes live for the first RESP cycle only.
            tap_we_q <= 1'b0;
            push_q   <= 1'b0;
            clr_q    <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (id_valid_i) begin
                            rs1_q     <= id_rs1_i;
                            idx_q     <= id_rs2_i[IDX_WIDTH-1:0];
                            rd_q      <= id_rd_i;
                            tag_q     <= id_tag_i;
                            wb_we_q   <= (id_op_i == OP_DOT);
                            wb_data_q <= '0;
                            if (id_op_i == OP_DOT) begin
                                state_q <= MAC;
                                acc_q   <= '0;
                                cnt_q   <= '0;
                            end else begin
                                state_q  <= RESP;
                                tap_we_q <= (id_op_i == OP_TAP);
                                push_q   <= (id_op_i == OP_PUSH);
                                clr_q    <= (id_op_i == OP_CLR);
                            end
                        end
                    end
                    MAC: begin
                        acc_q <= acc_sum;
                        if (cnt_q == LAST_K) begin
                            cnt_q     <= '0;
                            state_q   <= RESP;
                            wb_data_q <= result;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    RESP: begin
                        if (wb_ready_i) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign id_ready_o    = (state_q == IDLE);
    assign tap_we_o      = tap_we_q & ~flush_i;
    assign sample_push_o = push_q & ~flush_i;
    assign sample_clr_o  = clr_q & ~flush_i;
    assign tap_idx_o     = idx_q;
    assign ctrl_wdata_o  = rs1_q;
    assign wb_valid_o    = (state_q == RESP) & ~flush_i;
    assign wb_we_o       = wb_we_q;
    assign wb_rd_o       = rd_q;
    assign wb_data_o     = wb_data_q;
    assign wb_tag_o      = tag_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// tb/tb_fir_xifu_ex.sv - scoreboard testbench for fir_xifu_ex
module tb_fir_xifu_ex;
    localparam int NB  = 4;
    localparam int DW  = 16;
    localparam int SH  = 0;
    localparam int TW  = 4;
    localparam int TPW = 32 / DW;
    localparam int NW  = NB / TPW;
    localparam int IW  = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [1:0] PUSH = 2'b00;
    localparam logic [1:0] TAP  = 2'b01;
    localparam logic [1:0] DOT  = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           id_valid = 1'b0;
    logic           id_ready;
    logic [1:0]     id_op = '0;
    logic [31:0]    id_rs1 = '0;
    logic [31:0]    id_rs2 = '0;
    logic [4:0]     id_rd = '0;
    logic [TW-1:0]  id_tag = '0;
    logic [NB*DW-1:0] taps;
    logic [NB*DW-1:0] samples;
    logic           tap_we;
    logic [IW-1:0]  tap_idx;
    logic [31:0]    ctrl_wdata;
    logic           sample_push;
    logic           sample_clr;
    logic           wb_valid;
    logic           wb_ready = 1'b1;
    logic           wb_we;
    logic [4:0]     wb_rd;
    logic [31:0]    wb_data;
    logic [TW-1:0]  wb_tag;

    fir_xifu_ex #(.NB_TAPS(NB), .DATA_WIDTH(DW), .SHIFT(SH), .TAG_WIDTH(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .id_valid_i(id_valid), .id_ready_o(id_ready), .id_op_i(id_op),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_tag_i(id_tag),
        .taps_i(taps), .samples_i(samples),
        .tap_we_o(tap_we), .tap_idx_o(tap_idx), .ctrl_wdata_o(ctrl_wdata),
        .sample_push_o(sample_push), .sample_clr_o(sample_clr),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_we_o(wb_we),
        .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_tag_o(wb_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer contents as the bench's buffer controller holds them.
    logic signed [DW-1:0] m_tap [NB];
    logic signed [DW-1:0] m_smp [NB];
    always_comb begin
        taps    = '0;
        samples = '0;
        for (int k = 0; k < NB; k++) begin
            taps[k*DW +: DW]    = m_tap[k];
            samples[k*DW +: DW] = m_smp[k];
        end
    end

    typedef struct {
        logic          we;
        logic [4:0]    rd;
        logic [31:0]   data;
        logic [TW-1:0] tag;
        int            cyc;
    } wb_t;
    typedef struct {
        logic [1:0]    op;
        logic [IW-1:0] idx;
        logic [31:0]   data;
        int            cyc;
    } st_t;

    wb_t wb_q[$];
    st_t st_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    logic rdy_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Dot product from plain integer arithmetic, then shift and reduce to 32 bits.
    function automatic logic [31:0] dot_model();
        longint s;
        s = 0;
        for (int k = 0; k < NB; k++) s += longint'(m_tap[k]) * longint'(m_smp[k]);
        s = s >>> SH;
`ifdef FIR_XIFU_EX_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [2:0] strobe_bits(input logic [1:0] op);
        case (op)
            TAP:     return 3'b100;
            PUSH:    return 3'b010;
            CLR:     return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!id_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!id_ready) check("idle_timeout", 0, 1);
    endtask

    // Present an instruction and hold it until accepted; expectations are pushed at accept.
    task automatic issue(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic [TW-1:0] tag, output int acc_cyc);
        int  waited;
        wb_t w;
        st_t s;
        int  idx;
        waited = 0;
        @(posedge clk); #1;
        id_valid = 1'b1; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_tag = tag;
        @(negedge clk);
        while (!id_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!id_ready) begin
            check("accept_timeout", 0, 1);
            id_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        acc_cyc = cyc;
        w.we = (op == DOT); w.rd = rd; w.tag = tag;
        w.data = (op == DOT) ? dot_model() : 32'h0;
        w.cyc  = (op == DOT) ? acc_cyc + NB + 1 : acc_cyc + 1;
        wb_q.push_back(w);
        if (op != DOT) begin
            s.op = op; s.idx = rs2[IW-1:0]; s.data = rs1; s.cyc = acc_cyc + 1;
            st_q.push_back(s);
        end
        if (op == TAP) begin
            idx = int'(rs2[IW-1:0]);
            for (int j = 0; j < TPW; j++)
                if (idx * TPW + j < NB) m_tap[idx*TPW + j] = rs1[j*DW +: DW];
        end
        @(posedge clk); #1;
        id_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_rand) wb_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or a response.
    logic          pv = 1'b0, pr = 1'b0, p_we;
    logic [4:0]    p_rd;
    logic [31:0]   p_data;
    logic [TW-1:0] p_tag;
    int            ns;
    st_t           se;
    wb_t           we_e;
    always @(negedge clk) begin
        if (rst_n) begin
            ns = int'(tap_we) + int'(sample_push) + int'(sample_clr);
            if (ns != 0) begin
                if (ns > 1) check("strobe_onehot", ns, 1);
                if (st_q.size() == 0) begin
                    check("unexpected_strobe", {tap_we, sample_push, sample_clr}, 0);
                end else begin
                    se = st_q.pop_front();
                    check("strobe_kind", {tap_we, sample_push, sample_clr}, strobe_bits(se.op));
                    check("strobe_cycle", cyc, se.cyc);
                    if (se.op != CLR) check("ctrl_wdata", ctrl_wdata, se.data);
                    if (se.op == TAP) check("tap_idx", tap_idx, se.idx);
                end
            end
            if (wb_valid) begin
                if (!pv) begin
                    if (wb_q.size() == 0) check("unexpected_wb", 1, 0);
                    else check("wb_latency", cyc, wb_q[0].cyc);
                end else if (!pr) begin
                    check("wb_stable", {wb_we, wb_rd, wb_data, wb_tag}, {p_we, p_rd, p_data, p_tag});
                end
                if (wb_ready && wb_q.size() > 0) begin
                    we_e = wb_q.pop_front();
                    check("wb_we", wb_we, we_e.we);
                    check("wb_rd", wb_rd, we_e.rd);
                    check("wb_data", wb_data, we_e.data);
                    check("wb_tag", wb_tag, we_e.tag);
                end
            end
        end
        pv = wb_valid; pr = wb_ready;
        p_we = wb_we; p_rd = wb_rd; p_data = wb_data; p_tag = wb_tag;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int ac, pc, v, n;
    initial begin
        for (int k = 0; k < NB; k++) begin m_tap[k] = '0; m_smp[k] = '0; end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_strobes", {tap_we, sample_push, sample_clr}, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_fields", {wb_we, wb_rd, wb_data, wb_tag}, 0);
        check("rst_id_ready", id_ready, 1);

        // Tap words: low halfword lands in the lower tap index.
        issue(TAP, 32'h0002_0001, 32'd0, 5'd1, 4'd1, ac);
        issue(TAP, 32'h0004_0003, 32'd1, 5'd2, 4'd2, ac);
        wait_idle();
        for (int k = 0; k < NB; k++) m_smp[k] = 16'sd1;
        issue(DOT, 32'd0, 32'd0, 5'd7, 4'd9, ac);

        // Full-scale negative operands: sum is 2^32.
        wait_idle();
        for (int k = 0; k < NB; k++) begin m_tap[k] = 16'h8000; m_smp[k] = 16'h8000; end
        issue(DOT, 32'd0, 32'd0, 5'd3, 4'd4, ac);

        // Backpressure: response held three cycles while a PUSH waits.
        wait_idle();
        for (int k = 0; k < NB; k++) begin m_tap[k] = DW'(k + 1); m_smp[k] = DW'(3 - k); end
        wb_ready = 1'b0;
        issue(DOT, 32'd0, 32'd0, 5'd11, 4'd5, ac);
        n = 0;
        @(negedge clk);
        while (!wb_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_valid_seen", wb_valid, 1);
        v = cyc;
        fork
            issue(PUSH, 32'h0000_1234, 32'd0, 5'd12, 4'd6, pc);
            begin
                for (int i = 0; i < 3; i++) begin
                    check("bp_id_ready_low", id_ready, 0);
                    check("bp_valid_held", wb_valid, 1);
                    @(posedge clk); #1;
                end
                wb_ready = 1'b1;
            end
        join
        check("bp_accept_after_hs", pc, v + 4);

        // Flush in the second MAC cycle, then a DOT proving the accumulator restarted.
        wait_idle();
        issue(DOT, 32'd0, 32'd0, 5'd13, 4'd7, ac);
        @(posedge clk); #1;
        flush = 1'b1;
        void'(wb_q.pop_back());
        @(negedge clk);
        check("flush_valid_low", wb_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready_next", id_ready, 1);
        for (int k = 0; k < NB; k++) begin m_tap[k] = 16'sd1; m_smp[k] = 16'sd2; end
        issue(DOT, 32'd0, 32'd0, 5'd14, 4'd8, ac);

        // Flush together with a valid PUSH in IDLE: nothing accepted.
        wait_idle();
        @(posedge clk); #1;
        id_valid = 1'b1; id_op = PUSH; id_rs1 = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk); #1;
        id_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_noaccept", {sample_push, wb_valid}, 0);

        // Randomised mix with random writeback backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            if (op == DOT) begin
                wait_idle();
                for (int k = 0; k < NB; k++) begin
                    m_tap[k] = DW'($urandom);
                    m_smp[k] = DW'($urandom);
                end
            end
            issue(op, $urandom, $urandom, 5'($urandom), TW'($urandom), ac);
        end

        n = 0;
        while ((wb_q.size() != 0 || st_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        rdy_rand = 1'b0;
        check("drain_wb", wb_q.size(), 0);
        check("drain_strobe", st_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
